cpu_run_controller: RTL and testbench
=====================================

Name: cpu_run_controller

Overview:
- Run-control sequencer for pinAbstractedCPU, placed between the testbench/top level and the CPU core.
- Generates the CPU clock-enable and drives the boot-address mux select, replacing hand-toggled reset/CLK sequences.
- Sequences boot, then supports run, halt, single-step and halt-on-terminator (INS == 0).

Parameters:
- BOOT_CYCLES, 2, number of CLK cycles held in BOOT with boot_sel=1 and cpu_en=1 so the core latches boot_addr (valid range 1..15).
- CNT_W, 16, width of cycle_count.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- run_req  input  1  level/pulse; request free-running execution.
- halt_req  input  1  level/pulse; request halt.
- step_req  input  1  pulse; request execution of exactly one instruction.
- boot_addr  input  8  address driven to the CPU during BOOT.
- Addr_CPU  input  8  current CPU instruction address.
- INS  input  21  instruction currently fetched from ROM.
- cpu_en  output  1  CPU clock enable (combinational from state and inputs).
- boot_sel  output  1  select for bytemux2; 1 = Addr_MANUAL, 0 = Addr_CPU.
- Addr_MANUAL  output  8  registered copy of boot_addr.
- state  output  2  00 BOOT, 01 HALTED, 10 RUN, 11 STEP.
- step_done  output  1  one-cycle pulse after a STEP cycle completes.
- halt_ins  output  1  sticky flag: halted because INS == 0.
- cycle_count  output  CNT_W  number of enabled execute cycles.

Behaviour:
- Reset (synchronous, active-high): state=BOOT, boot_cnt=0, Addr_MANUAL=boot_addr, step_done=0, halt_ins=0, cycle_count=0. While in BOOT: boot_sel=1, cpu_en=1.
- Reset asserted in any state, including mid-RUN or mid-STEP, returns the block to BOOT on the next edge. Reset has highest priority.
- BOOT:
  - Counts BOOT_CYCLES cycles, then moves to HALTED.
  - boot_sel=1 for every BOOT cycle; boot_sel=0 in all other states.
  - Requests are ignored during BOOT.
- HALTED:
  - cpu_en=0.
  - Request priority: halt_req > step_req > run_req. If halt_req is active, stay in HALTED.
  - step_req → STEP. run_req → RUN. Clears halt_ins on leaving HALTED.
- RUN:
  - cpu_en=1 unless a halt condition exists this cycle.
  - Halt conditions: halt_req, or INS == 21'b0 (terminator). On a halt condition, cpu_en is forced to 0 in the same cycle (the offending instruction is not executed) and the next state is HALTED.
  - A terminator halt sets halt_ins=1.
  - run_req and step_req are ignored while in RUN.
- STEP:
  - Lasts exactly one cycle with cpu_en=1, then HALTED. step_done=1 in the following cycle only.
  - If INS == 0 in the STEP cycle: cpu_en=0, halt_ins=1, step_done still pulses.
  - halt_req during STEP does not abort the step.
- cycle_count:
  - Increments by 1 on every edge where cpu_en=1 and state is RUN or STEP.
  - Wraps from all-ones to 0 with no flag. Cleared only by reset.
- Latency:
  - run_req sampled in HALTED → first enabled cycle 1 cycle later.
  - halt_req in RUN → cpu_en low in the same cycle.

Optional Feature:
- Macro: RUNCTL_BREAKPOINT_EN.
- When defined, the block adds these ports:
  - bp_addr (input, 8)
  - bp_valid (input, 1)
  - bp_hit (output, 1, sticky)
- Breakpoint behaviour:
  - In RUN, Addr_CPU == bp_addr with bp_valid=1 is an additional halt condition: cpu_en=0 that cycle, next state HALTED, bp_hit=1.
  - Skip-once: the first RUN cycle after leaving HALTED ignores the breakpoint, so re-running from a breakpoint makes progress.
  - STEP never triggers the breakpoint.
  - bp_hit clears on run_req/step_req acceptance or on reset.
  - Priority: halt_req > terminator > breakpoint.
- When undefined, none of these ports or logic exist and behaviour is exactly as above.

Test Plan:
- Reset with boot_addr=8'h00, BOOT_CYCLES=2 → boot_sel=1 and cpu_en=1 for 2 cycles, then state=01, cpu_en=0, cycle_count=0.
- From HALTED pulse run_req; ROM program MOV R0,#5 / MOV R1,#7 / ADD R0,R0,R1 / 21'b0 → R0=12, state returns to 01, halt_ins=1, cycle_count=3.
- From HALTED issue 3 step_req pulses spaced 4 cycles apart → each gives exactly one cpu_en cycle and one step_done pulse; Addr_CPU advances by 1 per step; cycle_count=3.
- In RUN assert halt_req for 1 cycle at cycle_count=5 → cpu_en=0 in that cycle, state=01, cycle_count holds 5; halt_ins=0.
- In RUN (or STEP) assert reset → next edge state=00, cycle_count=0, boot_sel=1; simultaneous halt_req+step_req+run_req in HALTED → stays HALTED.
- RUNCTL_BREAKPOINT_EN, bp_addr=8'h02, bp_valid=1, run → halts with Addr_CPU=2, bp_hit=1; run_req again → executes address 2 (skip-once) and continues to terminator.

Source files
------------

// File: rtl/cpu_run_controller.sv
// Run-control sequencer for the pin-abstracted CPU: boot, run, halt, single-step.
// Optional breakpoint support is enabled by defining RUNCTL_BREAKPOINT_EN.
module cpu_run_controller #(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic [7:0]       boot_addr,
    input  logic [7:0]       Addr_CPU,
    input  logic [20:0]      INS,
`ifdef RUNCTL_BREAKPOINT_EN
    input  logic [7:0]       bp_addr,
    input  logic             bp_valid,
    output logic             bp_hit,
`endif
    output logic             cpu_en,
    output logic             boot_sel,
    output logic [7:0]       Addr_MANUAL,
    output logic [1:0]       state,
    output logic             step_done,
    output logic             halt_ins,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_HALTED = 2'b01,
        ST_RUN    = 2'b10,
        ST_STEP   = 2'b11
    } state_t;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t           state_q;
    logic [3:0]       boot_cnt_q;
    logic [7:0]       addr_manual_q;
    logic             step_done_q;
    logic             halt_ins_q;
    logic [CNT_W-1:0] cycle_count_q;

    logic ins_zero;
    logic bp_stop;
    logic run_stop;
    logic cpu_en_c;
    logic count_en;

    assign ins_zero = (INS == '0);

`ifdef RUNCTL_BREAKPOINT_EN
    logic first_run_q;
    logic bp_hit_q;

    // The first RUN cycle after HALTED skips the breakpoint so a resume makes progress.
    assign bp_stop = bp_valid && (Addr_CPU == bp_addr) && !first_run_q;
    assign bp_hit  = bp_hit_q;
`else
    logic unused_addr;

    assign bp_stop     = 1'b0;
    assign unused_addr = ^Addr_CPU;
`endif

    assign run_stop = halt_req | ins_zero | bp_stop;

    // The enable is combinational so a halt suppresses the offending instruction in the same cycle.
    always_comb begin
        cpu_en_c = 1'b0;
        case (state_q)
            ST_BOOT:   cpu_en_c = 1'b1;
            ST_HALTED: cpu_en_c = 1'b0;
            ST_RUN:    cpu_en_c = !run_stop;
            ST_STEP:   cpu_en_c = !ins_zero;
            default:   cpu_en_c = 1'b0;
        endcase
    end

    assign count_en = cpu_en_c && ((state_q == ST_RUN) || (state_q == ST_STEP));

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            boot_cnt_q    <= 4'd0;
            addr_manual_q <= boot_addr;
            step_done_q   <= 1'b0;
            halt_ins_q    <= 1'b0;
            cycle_count_q <= '0;
`ifdef RUNCTL_BREAKPOINT_EN
            first_run_q   <= 1'b0;
            bp_hit_q      <= 1'b0;
`endif
        end else begin
            addr_manual_q <= boot_addr;
            step_done_q   <= (state_q == ST_STEP);
            if (count_en) begin
                cycle_count_q <= cycle_count_q + 1'b1;
            end
`ifdef RUNCTL_BREAKPOINT_EN
            first_run_q <= 1'b0;
`endif
            case (state_q)
                ST_BOOT: begin
                    if (boot_cnt_q == BOOT_LAST) begin
                        state_q <= ST_HALTED;
                    end else begin
                        boot_cnt_q <= boot_cnt_q + 4'd1;
                    end
                end
                ST_HALTED: begin
                    if (!halt_req) begin
                        if (step_req) begin
                            state_q    <= ST_STEP;
                            halt_ins_q <= 1'b0;
`ifdef RUNCTL_BREAKPOINT_EN
                            bp_hit_q   <= 1'b0;
`endif
                        end else if (run_req) begin
                            state_q     <= ST_RUN;
                            halt_ins_q  <= 1'b0;
`ifdef RUNCTL_BREAKPOINT_EN
                            bp_hit_q    <= 1'b0;
                            first_run_q <= 1'b1;
`endif
                        end
                    end
                end
                ST_RUN: begin
                    if (run_stop) begin
                        state_q <= ST_HALTED;
                        // An explicit halt outranks the terminator, which outranks the breakpoint.
                        if (!halt_req && ins_zero) begin
                            halt_ins_q <= 1'b1;
                        end
`ifdef RUNCTL_BREAKPOINT_EN
                        if (!halt_req && !ins_zero && bp_stop) begin
                            bp_hit_q <= 1'b1;
                        end
`endif
                    end
                end
                ST_STEP: begin
                    state_q <= ST_HALTED;
                    if (ins_zero) begin
                        halt_ins_q <= 1'b1;
                    end
                end
                default: state_q <= ST_BOOT;
            endcase
        end
    end

    assign cpu_en      = cpu_en_c;
    assign boot_sel    = (state_q == ST_BOOT);
    assign Addr_MANUAL = addr_manual_q;
    assign state       = state_q;
    assign step_done   = step_done_q;
    assign halt_ins    = halt_ins_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
module tb_cpu_run_controller;

    localparam int CNT_W = 3;

    logic             CLK = 1'b0;
    logic             reset;
    logic             run_req;
    logic             halt_req;
    logic             step_req;
    logic [7:0]       boot_addr;
    logic [7:0]       Addr_CPU;
    logic [20:0]      INS;
    logic             cpu_en;
    logic             boot_sel;
    logic [7:0]       Addr_MANUAL;
    logic [1:0]       state;
    logic             step_done;
    logic             halt_ins;
    logic [CNT_W-1:0] cycle_count;
`ifdef RUNCTL_BREAKPOINT_EN
    logic [7:0]       bp_addr;
    logic             bp_valid;
    logic             bp_hit;
`endif

    cpu_run_controller #(.BOOT_CYCLES(2), .CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .run_req     (run_req),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .boot_addr   (boot_addr),
        .Addr_CPU    (Addr_CPU),
        .INS         (INS),
`ifdef RUNCTL_BREAKPOINT_EN
        .bp_addr     (bp_addr),
        .bp_valid    (bp_valid),
        .bp_hit      (bp_hit),
`endif
        .cpu_en      (cpu_en),
        .boot_sel    (boot_sel),
        .Addr_MANUAL (Addr_MANUAL),
        .state       (state),
        .step_done   (step_done),
        .halt_ins    (halt_ins),
        .cycle_count (cycle_count)
    );

    always #5 CLK = ~CLK;

    logic [20:0] rom [256];
    logic [7:0]  pc = 8'd0;
    logic [7:0]  regs [4];
    logic [20:0] cur;

    assign Addr_CPU = pc;
    assign INS      = rom[pc];

    always @(posedge CLK) begin
        if (reset) begin
            for (int r = 0; r < 4; r++) regs[r] <= 8'd0;
        end
        if (cpu_en === 1'b1) begin
            if (boot_sel) begin
                pc <= Addr_MANUAL;
            end else begin
                cur = rom[pc];
                case (cur[20:18])
                    3'b001: regs[cur[17:16]] <= cur[7:0];
                    3'b010: regs[cur[17:16]] <= regs[cur[15:14]] + regs[cur[13:12]];
                    default: ;
                endcase
                pc <= pc + 8'd1;
            end
        end
    end

    typedef enum int {S_STATE, S_CPU_EN, S_BOOT_SEL, S_STEP_DONE, S_HALT_INS,
                      S_CNT, S_PC, S_R0, S_ADDR_MAN, S_BP_HIT} sig_e;
    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] actual_of(input sig_e s);
        case (s)
            S_STATE:     return 32'(state);
            S_CPU_EN:    return 32'(cpu_en);
            S_BOOT_SEL:  return 32'(boot_sel);
            S_STEP_DONE: return 32'(step_done);
            S_HALT_INS:  return 32'(halt_ins);
            S_CNT:       return 32'(cycle_count);
            S_PC:        return 32'(pc);
            S_R0:        return 32'(regs[0]);
            S_ADDR_MAN:  return 32'(Addr_MANUAL);
`ifdef RUNCTL_BREAKPOINT_EN
            S_BP_HIT:    return 32'(bp_hit);
`endif
            default:     return 32'd0;
        endcase
    endfunction

    logic [31:0] act;
    always @(negedge CLK) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                act = actual_of(sb[i].sig);
                n_checks++;
                if (act !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: got %0d, expected %0d", sb[i].name, cyc, act, sb[i].val);
                end else begin
                    $display("ok   %s cycle %0d: %0d", sb[i].name, cyc, act);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input int off, input sig_e s, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + off;
        e.sig  = s;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic do_reset(input logic [7:0] addr);
        boot_addr = addr;
        reset     = 1'b1;
        tick(1);
        reset     = 1'b0;
        chk(0, S_STATE, 0, "rst_boot");
        tick(2);
        chk(0, S_STATE, 1, "rst_halted");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {3'b001, 2'd2, 8'd0, 8'(i)};
        rom[0] = {3'b001, 2'd0, 8'd0, 8'd5};
        rom[1] = {3'b001, 2'd1, 8'd0, 8'd7};
        rom[2] = {3'b010, 2'd0, 2'd0, 2'd1, 12'd0};
        rom[3] = 21'd0;
        reset = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; boot_addr = 8'h00;
`ifdef RUNCTL_BREAKPOINT_EN
        bp_addr = 8'h00; bp_valid = 1'b0;
`endif

        tick(2);
        reset = 1'b0;
        chk(0, S_STATE, 0, "boot_state");   chk(0, S_BOOT_SEL, 1, "boot_sel");
        chk(0, S_CPU_EN, 1, "boot_en");     chk(0, S_CNT, 0, "boot_cnt");
        chk(0, S_STEP_DONE, 0, "boot_sd");  chk(0, S_HALT_INS, 0, "boot_hi");
        chk(0, S_ADDR_MAN, 0, "boot_amn");
        chk(1, S_STATE, 0, "boot2_state");  chk(1, S_BOOT_SEL, 1, "boot2_sel");
        chk(1, S_CPU_EN, 1, "boot2_en");
        chk(2, S_STATE, 1, "halt_state");   chk(2, S_CPU_EN, 0, "halt_en");
        chk(2, S_BOOT_SEL, 0, "halt_sel");  chk(2, S_CNT, 0, "halt_cnt");
        chk(3, S_STATE, 1, "boot_ign_run");
        tick(1);
        run_req = 1'b1;
        tick(1);
        run_req = 1'b0;
        tick(1);

        run_req = 1'b1;
        chk(0, S_CPU_EN, 0, "halted_en");
        tick(1);
        run_req = 1'b0;
        chk(0, S_STATE, 2, "run_state");    chk(0, S_CPU_EN, 1, "run_en");
        chk(0, S_CNT, 0, "run_cnt0");       chk(0, S_PC, 0, "run_pc0");
        chk(3, S_STATE, 2, "term_state");   chk(3, S_CPU_EN, 0, "term_en");
        chk(3, S_CNT, 3, "term_cnt");       chk(3, S_PC, 3, "term_pc");
        chk(4, S_STATE, 1, "term_halted");  chk(4, S_HALT_INS, 1, "term_hi");
        chk(4, S_CNT, 3, "term_cnt_hold");  chk(4, S_R0, 12, "prog_r0");
        tick(4);

        run_req = 1'b1;
        tick(1);
        run_req = 1'b0;
        chk(0, S_STATE, 2, "rerun_state");  chk(0, S_CPU_EN, 0, "rerun_en");
        chk(0, S_HALT_INS, 0, "rerun_hi_clr");
        chk(1, S_STATE, 1, "rerun_halted"); chk(1, S_HALT_INS, 1, "rerun_hi");
        chk(1, S_CNT, 3, "rerun_cnt");
        tick(1);

        halt_req = 1'b1; step_req = 1'b1; run_req = 1'b1;
        tick(1);
        halt_req = 1'b0; step_req = 1'b0; run_req = 1'b0;
        chk(0, S_STATE, 1, "prio_state");   chk(0, S_HALT_INS, 1, "prio_hi");
        chk(1, S_STATE, 1, "prio_state2");
        tick(1);

        do_reset(8'h00);
        n_checks++;
        if (state !== 2'b01) begin
            n_fail++;
            $display("FAIL imm_state: got %0d, expected 1", state);
        end else begin
            $display("ok   imm_state: %0d", state);
        end
        n_checks++;
        if (cpu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL imm_en: got %0d, expected 0", cpu_en);
        end else begin
            $display("ok   imm_en: %0d", cpu_en);
        end
        n_checks++;
        if (boot_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL imm_sel: got %0d, expected 0", boot_sel);
        end else begin
            $display("ok   imm_sel: %0d", boot_sel);
        end
        n_checks++;
        if (cycle_count !== '0) begin
            n_fail++;
            $display("FAIL imm_cnt: got %0d, expected 0", cycle_count);
        end else begin
            $display("ok   imm_cnt: %0d", cycle_count);
        end
        for (int i = 0; i < 3; i++) begin
            step_req = 1'b1;
            tick(1);
            step_req = 1'b0;
            if (i == 1) halt_req = 1'b1;
            chk(0, S_STATE, 3, "step_state");    chk(0, S_CPU_EN, 1, "step_en");
            chk(0, S_STEP_DONE, 0, "step_sd0");
            chk(1, S_STATE, 1, "step_halted");   chk(1, S_STEP_DONE, 1, "step_sd1");
            chk(1, S_PC, 32'(i + 1), "step_pc"); chk(1, S_CNT, 32'(i + 1), "step_cnt");
            chk(2, S_STEP_DONE, 0, "step_sd2");
            tick(1);
            halt_req = 1'b0;
            tick(2);
        end
        chk(0, S_R0, 12, "step_r0");

        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        chk(0, S_STATE, 3, "tstep_state");  chk(0, S_CPU_EN, 0, "tstep_en");
        chk(1, S_STEP_DONE, 1, "tstep_sd"); chk(1, S_HALT_INS, 1, "tstep_hi");
        chk(1, S_CNT, 3, "tstep_cnt");      chk(1, S_PC, 3, "tstep_pc");
        tick(3);

        do_reset(8'd16);
        run_req = 1'b1;
        tick(1);
        run_req = 1'b0;
        chk(0, S_PC, 16, "long_pc0");
        tick(5);
        halt_req = 1'b1;
        chk(0, S_CPU_EN, 0, "hreq_en");     chk(0, S_STATE, 2, "hreq_state");
        chk(0, S_CNT, 5, "hreq_cnt");
        tick(1);
        halt_req = 1'b0;
        chk(0, S_STATE, 1, "hreq_halted");  chk(0, S_CNT, 5, "hreq_cnt_hold");
        chk(0, S_HALT_INS, 0, "hreq_hi");   chk(0, S_PC, 21, "hreq_pc");
        run_req = 1'b1;
        tick(1);
        run_req = 1'b0;
        chk(0, S_STATE, 2, "res_state");    chk(0, S_CNT, 5, "res_cnt");
        chk(2, S_CNT, 7, "cnt_max");        chk(3, S_CNT, 0, "cnt_wrap");
        chk(4, S_CNT, 1, "cnt_after_wrap");
        tick(4);
        reset = 1'b1;
        chk(0, S_STATE, 2, "mid_run_state"); chk(0, S_CPU_EN, 1, "mid_run_en");
        tick(1);
        reset = 1'b0;
        chk(0, S_STATE, 0, "rrst_state");   chk(0, S_CNT, 0, "rrst_cnt");
        chk(0, S_BOOT_SEL, 1, "rrst_sel");  chk(0, S_CPU_EN, 1, "rrst_en");
        chk(0, S_ADDR_MAN, 16, "rrst_amn");
        tick(2);

`ifdef RUNCTL_BREAKPOINT_EN
        do_reset(8'h00);
        bp_addr = 8'h02; bp_valid = 1'b1;
        run_req = 1'b1;
        tick(1);
        run_req = 1'b0;
        chk(0, S_CPU_EN, 1, "bp_en0");      chk(2, S_CPU_EN, 0, "bp_en_stop");
        chk(2, S_PC, 2, "bp_pc");
        chk(3, S_STATE, 1, "bp_halted");    chk(3, S_BP_HIT, 1, "bp_hit");
        chk(3, S_PC, 2, "bp_pc_hold");      chk(3, S_CNT, 2, "bp_cnt");
        chk(3, S_HALT_INS, 0, "bp_hi");
        tick(3);
        run_req = 1'b1;
        tick(1);
        run_req = 1'b0;
        chk(0, S_STATE, 2, "bp_skip_state"); chk(0, S_CPU_EN, 1, "bp_skip_en");
        chk(0, S_BP_HIT, 0, "bp_hit_clr");
        chk(2, S_STATE, 1, "bp_term");      chk(2, S_HALT_INS, 1, "bp_term_hi");
        chk(2, S_R0, 12, "bp_r0");          chk(2, S_CNT, 3, "bp_cnt_end");
        tick(3);
        bp_valid = 1'b0;
`endif

        tick(2);
        while (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got unchecked, expected checked at cycle %0d", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
